bcd_entry_display: RTL and testbench
====================================

Name: bcd_entry_display

Overview:
- Board-level top for the DE1 entry/display lab.
- The user starts an entry with KEY[3], then keys in a signed 3-digit decimal number one digit at a time: SW[3:0] is the digit, SW[9] is the sign, KEY[3] commits.
- The digit being entered blinks on HEX0..HEX2, and HEX3 shows the sign.
- The committed magnitude is shown in binary on LEDR.

Parameters:
- BLINK_HALF, default 12_500_000: clock cycles per blink half-period (2 Hz blink at 50 MHz). Benches use a small value, e.g. 8.

Ports:
- CLOCK_50  in  1   system clock, all state on its rising edge.
- KEY  in  4   push buttons, active-low. KEY[0] is rst_n: asynchronous, active-low reset. KEY[3] is the enter key. KEY[2:1] are unused.
- SW  in  10   SW[3:0] digit value, SW[9] sign (1 = negative), SW[8:4] unused.
- LEDG  out  8   LEDG[2:0] one-hot entry position (bit0 ones, bit1 tens, bit2 hundreds); LEDG[7:3] = 0.
- LEDR  out  10   committed magnitude, unsigned binary 0..999.
- HEX0  out  7   ones digit, active-low, bit0 = segment a ... bit6 = segment g.
- HEX1  out  7   tens digit, same encoding.
- HEX2  out  7   hundreds digit, same encoding.
- HEX3  out  7   sign: 7'h3F ("-") if the committed sign is 1, else 7'h7F (blank).

Behaviour:
- Enter key input: KEY[3] passes through a 2-FF synchronizer. A press event is a single-cycle pulse on the synchronized high-to-low transition.
  - Holding the key gives exactly one event.
  - No debounce filter; one clean press = one event.
- State machine (track_inp, 2 bits): IDLE=0, ONES=1, TENS=2, HUNS=3. Transitions on press events:
  - IDLE->ONES: clears working digits d0, d1, d2 to 0 and restarts the blink counter in the visible phase.
  - ONES->TENS: d0 <= digit.
  - TENS->HUNS: d1 <= digit.
  - HUNS->IDLE: d2 <= digit; LEDR <= d2*100 + d1*10 + digit; sign <= SW[9].
- Digit value: SW[3:0] saturated to 9 (values A..F commit as 9).
- Flash flags, one-hot by state:
  - flash_ones_display = (state==ONES).
  - flash_tens_display = (state==TENS).
  - flash_huns_display = (state==HUNS).
  - All flags are 0 in IDLE.
- Displays:
  - A non-flashing digit shows its stored d value.
  - A flashing digit shows the live saturated SW[3:0] during the visible phase and 7'h7F during the blank phase.
- Blink counter: free-running while not IDLE. When it reaches BLINK_HALF-1 it wraps to 0 and toggles the phase.
- Encoding: digit 0..9 = 40,79,24,30,19,12,02,78,00,10 (hex).
- LEDG = one-hot of the flashing position; 0 in IDLE.
- Latency:
  - A press event updates state and registers on the next clock edge.
  - HEX, LEDG and LEDR are combinational from registers; LEDR and HEX3 change on the same edge that returns to IDLE.
- Reset (KEY[0] low, asynchronous), any state including mid-entry:
  - state = IDLE; d0 = d1 = d2 = 0; LEDR = 0; sign = 0; blink phase visible.
  - Outputs: HEX0-2 = 7'h40, HEX3 = 7'h7F, LEDG = 0.
  - A partial entry is discarded.
- A press event and reset release in the same cycle: reset wins.

Decomposition:
- Package bcd_entry_pkg: state enum (IDLE/ONES/TENS/HUNS), segment constants SEG_BLANK=7'h7F and SEG_MINUS=7'h3F, and the digit encoding table.
- One sub-module, seg7_decoder (4-bit digit -> 7-bit active-low segments), instantiated three times.
- The BCD-to-binary multiply-add stays inline in the top.

Test Plan:
1. Reset with KEY[0]=0 -> HEX0-2 = 40, HEX3 = 7F, LEDR = 0, LEDG = 0, track_inp = 0.
2. Start entry; then SW=3 press, SW=2 press, SW=1 press, with SW[9]=0 -> track_inp steps 1,2,3,0. Final result: HEX0 = 30, HEX1 = 24, HEX2 = 79, LEDR = 123 (0x07B), HEX3 = 7F.
3. Repeat the sequence with digits 5, 7, 8 and SW[9]=1 -> LEDR = 875 (0x36B), HEX3 = 3F. Then enter 0, 4, 4 -> LEDR = 440 (0x1B8).
4. With BLINK_HALF=8, in state TENS with SW=6 -> HEX1 alternates between 02 and 7F every 8 cycles. HEX0 holds its committed value steadily. LEDG = 3'b010.
5. Enter SW=0xC as the ones digit -> d0 = 9, HEX0 = 10. Hold KEY[3] low for 100 cycles -> exactly one state advance.
6. Assert KEY[0] low while in HUNS -> immediate IDLE, all digits 0, LEDR keeps no partial value (it is 0 after reset).

Source files
------------

// File: rtl/bcd_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_entry_pkg
// Summary  : Shared entry-state encoding and seven-segment constants.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_entry_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONES = 2'd1,
        TENS = 2'd2,
        HUNS = 2'd3
    } entry_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // Active-low patterns, element N is digit N.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decoder
// Summary  : Decimal digit to active-low seven-segment pattern.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import bcd_entry_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_digit <= 4'd9) begin
            o_seg = SEG_DIGITS[i_digit];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_entry_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_entry_display
// Summary  : DE1 signed 3-digit decimal entry with blinking cursor digit,
//            sign display and binary magnitude on LEDR.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_entry_display
    import bcd_entry_pkg::*;
#(
    parameter int BLINK_HALF = 12_500_000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [7:0] LEDG,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3
);

    localparam int                 c_cnt_w      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [c_cnt_w-1:0] c_blink_last = c_cnt_w'(BLINK_HALF - 1);

    logic               w_rst_n;
    logic               w_unused;
    logic [2:0]         r_key3_pipe;
    logic               w_press;
    logic [3:0]         w_digit;
    logic [9:0]         w_value;
    entry_state_t       r_track_inp;
    entry_state_t       w_track_nxt;
    logic [2:0][3:0]    r_d;
    logic [9:0]         r_ledr;
    logic               r_sign;
    logic [c_cnt_w-1:0] r_blink_cnt;
    logic               r_blink_on;
    logic [2:0]         w_flash;
    logic [2:0][6:0]    w_seg;
    logic [2:0][6:0]    w_hex;

    assign w_rst_n  = KEY[0];
    assign w_unused = ^{KEY[2:1], SW[8:4]};

    // [0] metastability stage, [1] synchronized level, [2] previous level.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_key3_pipe <= 3'b111;
        end else begin
            r_key3_pipe <= {r_key3_pipe[1:0], KEY[3]};
        end
    end

    assign w_press = r_key3_pipe[2] & ~r_key3_pipe[1];
    assign w_digit = (SW[3:0] > 4'd9) ? 4'd9 : SW[3:0];
    assign w_value = 10'(w_digit) * 10'd100 + 10'(r_d[1]) * 10'd10 + 10'(r_d[0]);

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_track_inp <= IDLE;
        end else begin
            r_track_inp <= w_track_nxt;
        end
    end

    always_comb begin
        w_track_nxt = r_track_inp;
        if (w_press) begin
            case (r_track_inp)
                IDLE:    w_track_nxt = ONES;
                ONES:    w_track_nxt = TENS;
                TENS:    w_track_nxt = HUNS;
                default: w_track_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_d    <= '0;
            r_ledr <= '0;
            r_sign <= 1'b0;
        end else if (w_press) begin
            case (r_track_inp)
                IDLE: r_d    <= '0;
                ONES: r_d[0] <= w_digit;
                TENS: r_d[1] <= w_digit;
                default: begin
                    r_d[2] <= w_digit;
                    r_ledr <= w_value;
                    r_sign <= SW[9];
                end
            endcase
        end
    end

    // Held cleared in IDLE so every new entry starts in the visible phase.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_track_inp == IDLE) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_flash = {r_track_inp == HUNS, r_track_inp == TENS, r_track_inp == ONES};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digits
            logic [3:0] w_sel;

            assign w_sel = w_flash[gi] ? w_digit : r_d[gi];

            seg7_decoder u_dec (
                .i_digit (w_sel),
                .o_seg   (w_seg[gi])
            );

            assign w_hex[gi] = (w_flash[gi] && !r_blink_on) ? SEG_BLANK : w_seg[gi];
        end
    endgenerate

    assign HEX0 = w_hex[0];
    assign HEX1 = w_hex[1];
    assign HEX2 = w_hex[2];
    assign HEX3 = r_sign ? SEG_MINUS : SEG_BLANK;
    assign LEDG = {5'b00000, w_flash};
    assign LEDR = r_ledr;

endmodule
`default_nettype wire

// File: tb/tb_bcd_entry_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_entry_display
// Summary  : Scoreboard bench for bcd_entry_display.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_entry_display;

    localparam int BLINK_HALF = 8;

    logic       CLOCK_50 = 1'b0;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [7:0] LEDG;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    always #5 CLOCK_50 = ~CLOCK_50;

    bcd_entry_display #(.BLINK_HALF(BLINK_HALF)) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .SW       (SW),
        .LEDG     (LEDG),
        .LEDR     (LEDR),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3)
    );

    typedef struct packed {
        logic [7:0]      ledg;
        logic [9:0]      ledr;
        logic [6:0]      hex3;
        logic [2:0][6:0] hex;
        logic [2:0]      hex_mask;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    int m_state;
    int m_d[3];
    int m_ledr;
    bit m_sign;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_d     = '{0, 0, 0};
        m_ledr  = 0;
        m_sign  = 1'b0;
    endtask

    task automatic model_press(input logic [3:0] sw, input bit sgn);
        int sat;
        sat = (sw > 9) ? 9 : int'(sw);
        case (m_state)
            0: begin m_d = '{0, 0, 0}; m_state = 1; end
            1: begin m_d[0] = sat; m_state = 2; end
            2: begin m_d[1] = sat; m_state = 3; end
            default: begin
                m_d[2] = sat;
                m_ledr = sat * 100 + m_d[1] * 10 + m_d[0];
                m_sign = sgn;
                m_state = 0;
            end
        endcase
    endtask

    task automatic push_expect(input string tag);
        exp_t e;
        e.ledg = (m_state == 0) ? 8'h00 : 8'(1 << (m_state - 1));
        e.ledr = 10'(m_ledr);
        e.hex3 = m_sign ? 7'h3F : 7'h7F;
        for (int p = 0; p < 3; p++) begin
            e.hex_mask[p] = (m_state != p + 1);
            e.hex[p]      = enc(m_d[p]);
        end
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_outputs();
        exp_t           e;
        string          t;
        logic [2:0][6:0] got_hex;
        chk("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            got_hex = {HEX2, HEX1, HEX0};
            chk({t, "/ledg"}, LEDG, e.ledg);
            chk({t, "/ledr"}, LEDR, e.ledr);
            chk({t, "/hex3"}, HEX3, e.hex3);
            for (int p = 0; p < 3; p++) begin
                if (e.hex_mask[p]) chk($sformatf("%s/hex%0d", t, p), got_hex[p], e.hex[p]);
            end
        end
    endtask

    task automatic do_press(input logic [3:0] sw, input bit sgn, input int hold, input string tag);
        model_press(sw, sgn);
        push_expect(tag);
        @(negedge CLOCK_50);
        SW     = {sgn, 5'b00000, sw};
        KEY[3] = 1'b0;
        repeat (hold) @(negedge CLOCK_50);
        KEY[3] = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        check_outputs();
    endtask

    task automatic apply_reset(input string tag);
        model_reset();
        push_expect(tag);
        @(negedge CLOCK_50);
        #2 KEY[0] = 1'b0;
        #1 check_outputs();
        repeat (2) @(negedge CLOCK_50);
        KEY[0] = 1'b1;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic blink_test();
        logic [6:0] v0;
        logic [6:0] v;
        bit         found;
        @(negedge CLOCK_50);
        SW    = 10'd6;
        found = 1'b0;
        @(negedge CLOCK_50);
        v0 = HEX1;
        for (int k = 0; k < 3 * BLINK_HALF; k++) begin
            @(negedge CLOCK_50);
            if (HEX1 !== v0) begin
                found = 1'b1;
                break;
            end
        end
        chk("blink_edge_seen", found, 1);
        v = HEX1;
        chk("blink_legal", (v == 7'h02) || (v == 7'h7F), 1);
        repeat (BLINK_HALF - 1) @(negedge CLOCK_50);
        chk("blink_hold", HEX1, v);
        chk("blink_ones_steady_a", HEX0, enc(2));
        @(negedge CLOCK_50);
        chk("blink_toggle", HEX1, (v == 7'h02) ? 7'h7F : 7'h02);
        chk("blink_ones_steady_b", HEX0, enc(2));
        chk("blink_ledg", LEDG, 8'h02);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        KEY = 4'b1111;
        SW  = 10'd0;
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        apply_reset("reset");

        do_press(4'd0, 1'b0, 4, "start_a");
        do_press(4'd3, 1'b0, 4, "ones_3");
        do_press(4'd2, 1'b0, 4, "tens_2");
        do_press(4'd1, 1'b0, 4, "huns_1");

        do_press(4'd0, 1'b1, 4, "start_b");
        do_press(4'd5, 1'b1, 4, "ones_5");
        do_press(4'd7, 1'b1, 4, "tens_7");
        do_press(4'd8, 1'b1, 4, "huns_8");

        do_press(4'd0, 1'b0, 4, "start_c");
        do_press(4'd0, 1'b0, 4, "ones_0");
        do_press(4'd4, 1'b0, 4, "tens_4");
        do_press(4'd4, 1'b0, 4, "huns_4");

        do_press(4'd0, 1'b0, 4, "start_d");
        do_press(4'd2, 1'b0, 4, "ones_2");
        blink_test();
        do_press(4'd6, 1'b1, 4, "tens_6");
        do_press(4'd1, 1'b1, 4, "huns_1_neg");

        do_press(4'd0, 1'b0, 4, "start_e");
        do_press(4'hC, 1'b0, 4, "ones_sat");
        do_press(4'd1, 1'b0, 100, "tens_long_hold");
        apply_reset("reset_mid_huns");

        do_press(4'd0, 1'b0, 4, "start_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
